// File: rtl/inc_arb_pkg.sv
// Shared definitions for the increment-counter arbiter.
// Contents:
//   arb_state_e  - arbiter FSM state (IDLE, BUSY, HANDOFF)
//   COUNT_W_DEF  - default counter value width
//   idx_width()  - index width for a given requester count (never below 1)
package inc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HANDOFF = 2'd2
    } arb_state_e;

    localparam int unsigned COUNT_W_DEF = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inc_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at (last+1) mod NREQ, upward with wrap, and returns the
// first set bit both as a one-hot vector and as an index.
// Ports:
//   req      - request vector
//   last     - index of the most recent winner
//   pick_oh  - one-hot winner (zero when no request)
//   pick_idx - winner index (zero when no request)
//   any      - at least one request is set
module rr_pick
    import inc_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick_oh,
    output logic [IW-1:0]   pick_idx,
    output logic            any
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        any      = |req;
        // k = 1..NREQ visits every index once, ending on last itself.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found         = 1'b1;
                pick_oh[cand] = 1'b1;
                pick_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/inc_arbiter.sv
// Round-robin arbiter sharing one modulo-n increment counter between NREQ
// requesters. The owner's increment strobes gate the counter enable; each
// post-increment count is returned to its requester two cycles later.
// Optional feature: define INC_ARB_LOCK_EN to add a 'lock' input that
// suppresses burst-limit rotation while the owner holds it.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-low reset
//   req        - per-requester ownership request (level)
//   inc_req    - per-requester increment strobe (owner only)
//   lock       - (INC_ARB_LOCK_EN only) hold ownership past MAXBURST
//   grant      - one-hot ownership (registered)
//   enable     - counter enable (combinational)
//   count_in   - counter value
//   done       - one-cycle completion pulse
//   done_owner - requester index of the completed increment
//   done_count - post-increment counter value
module inc_arbiter
    import inc_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAXBURST = 8,
    parameter int unsigned COUNT_W  = COUNT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         inc_req,
`ifdef INC_ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic [NREQ-1:0]         grant,
    output logic                    enable,
    input  logic [COUNT_W-1:0]      count_in,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_owner,
    output logic [COUNT_W-1:0]      done_count
);

    localparam int unsigned IW = idx_width(NREQ);

    arb_state_e        state_q;
    logic [NREQ-1:0]   grant_q;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     last_q;
    logic [7:0]        burst_q;
    logic              s1_valid_q;
    logic [IW-1:0]     s1_owner_q;
    logic              done_q;
    logic [IW-1:0]     done_owner_q;
    logic [COUNT_W-1:0] done_count_q;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic              competitor;
    logic              limit_hit;
    logic              lock_hold;
    logic [8:0]        burst_inc;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req      (req),
        .last     (last_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

`ifdef INC_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign owner_req  = req[owner_q];
    // req gates the strobe, so a simultaneous release and strobe does nothing.
    assign enable     = (state_q == BUSY) & grant_q[owner_q] & owner_req & inc_req[owner_q];
    assign competitor = |(req & ~grant_q);
    assign burst_inc  = {1'b0, burst_q} + 9'd1;
    assign limit_hit  = enable && (burst_inc == 9'(MAXBURST));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_q       <= IW'(NREQ - 1);
            burst_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_owner_q   <= '0;
            done_q       <= 1'b0;
            done_owner_q <= '0;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, HANDOFF: begin
                    burst_q <= '0;
                    if (pick_any) begin
                        grant_q <= pick_oh;
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                        state_q <= BUSY;
                    end else begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        grant_q <= '0;
                        burst_q <= '0;
                        state_q <= HANDOFF;
                    end else if (limit_hit) begin
                        // Limit reached: rotate only if someone else is waiting.
                        burst_q <= '0;
                        if (competitor && !lock_hold) begin
                            grant_q <= '0;
                            state_q <= HANDOFF;
                        end
                    end else if (enable) begin
                        burst_q <= burst_q + 8'd1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    burst_q <= '0;
                    state_q <= IDLE;
                end
            endcase

            // Completion pipeline: owner at t+1, counter value at t+2.
            s1_valid_q <= enable;
            s1_owner_q <= owner_q;
            done_q     <= s1_valid_q;
            if (s1_valid_q) begin
                done_owner_q <= s1_owner_q;
                done_count_q <= count_in;
            end
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign done_owner = done_owner_q;
    assign done_count = done_count_q;

endmodule
